// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control unit
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
    S_EXEC_I, S_ALUWB_R, S_ALUWB_I, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// rtl/multicycle_ctrl_alu_dec.sv - opcode/funct to ALU operation decode with legality flag
module multicycle_ctrl_alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    if (op == OP_RTYPE) begin
      legal = 1'b1;
      case (funct)
        FN_ADD:  alu_op = ALU_ADD;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_XOR:  alu_op = ALU_XOR;
        FN_SLT:  alu_op = ALU_SLT;
        FN_SLTU: alu_op = ALU_SLTU;
        default: legal  = 1'b0;
      endcase
    end else begin
      legal = 1'b1;
      case (op)
        OP_ADDI: alu_op = ALU_ADD;
        OP_SLTI: alu_op = ALU_SLT;
        OP_ANDI: alu_op = ALU_AND;
        OP_ORI:  alu_op = ALU_OR;
        OP_XORI: alu_op = ALU_XOR;
        default: legal  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory-wait timeout and trap
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op_i,
  input  logic [5:0]          funct_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                pc_write,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                alu_srca,
  output logic [1:0]          alu_srcb,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_src,
  output logic                retire_o,
  output logic                err_o,
  output logic [1:0]          err_code_o
);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       err_code;
  logic [3:0]       dec_alu_op;
  logic             dec_legal;
  logic             timeout;

  multicycle_ctrl_alu_dec u_alu_dec (
    .op     (op_i),
    .funct  (funct_i),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // Last tolerated wait cycle expired without ready: abandon the access.
  assign timeout = is_wait_state(state) && !mem_ready_i &&
                   (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      err_code <= ERR_NONE;
    end else begin
      if (is_wait_state(state) && !mem_ready_i && !timeout)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      if (timeout) begin
        state <= S_TRAP;
        if (err_code == ERR_NONE) err_code <= ERR_TIMEOUT;
      end else begin
        case (state)
          S_FETCH:  if (mem_ready_i) state <= S_DECODE;
          S_DECODE: begin
            if (op_i == OP_LW || op_i == OP_SW)        state <= S_MEMADR;
            else if (op_i == OP_BEQ || op_i == OP_BNE) state <= S_BRANCH;
            else if (op_i == OP_J)                     state <= S_JUMP;
            else if (dec_legal)
              state <= (op_i == OP_RTYPE) ? S_EXEC_R : S_EXEC_I;
            else begin
              state <= S_TRAP;
              if (err_code == ERR_NONE) err_code <= ERR_ILLEGAL;
            end
          end
          S_MEMADR:  state <= (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
          S_MEMRD:   if (mem_ready_i) state <= S_MEMWB;
          S_MEMWR:   if (mem_ready_i) state <= S_FETCH;
          S_EXEC_R:  state <= S_ALUWB_R;
          S_EXEC_I:  state <= S_ALUWB_I;
          S_MEMWB, S_ALUWB_R, S_ALUWB_I, S_BRANCH, S_JUMP: state <= S_FETCH;
          S_TRAP:    state <= S_TRAP;
          default:   state <= S_FETCH;
        endcase
      end
    end
  end

  logic [3:0] alu_op_int;

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_srca   = 1'b0;
    alu_srcb   = SRCB_RT;
    alu_op_int = ALU_ADD;
    pc_src     = PCSRC_ALU;
    retire_o   = 1'b0;
    err_o      = 1'b0;
    err_code_o = err_code;
    case (state)
      S_FETCH: begin
        mem_read = !timeout;
        if (mem_ready_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          alu_srcb = SRCB_FOUR;
        end
      end
      S_DECODE: alu_srcb = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_srca = 1'b1;
        alu_srcb = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = !timeout;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_o   = 1'b1;
      end
      S_MEMWR: begin
        mem_write = !timeout;
        i_or_d    = 1'b1;
        retire_o  = mem_ready_i;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_srca   = 1'b1;
        alu_srcb   = (state == S_EXEC_R) ? SRCB_RT : SRCB_IMM;
        alu_op_int = dec_alu_op;
      end
      S_ALUWB_R, S_ALUWB_I: begin
        reg_write = 1'b1;
        reg_dst   = (state == S_ALUWB_R);
        retire_o  = 1'b1;
      end
      S_BRANCH: begin
        alu_srca   = 1'b1;
        alu_op_int = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_write   = (op_i == OP_BNE) ? !zero_i : zero_i;
        retire_o   = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        retire_o = 1'b1;
      end
      S_TRAP: begin
        err_o      = 1'b1;
        alu_op_int = 4'b0000;
      end
      default: ;
    endcase
    // Reset must never leak a write strobe, so everything is gated here.
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      alu_srca   = 1'b0;
      alu_srcb   = 2'b00;
      alu_op_int = 4'b0000;
      pc_src     = 2'b00;
      retire_o   = 1'b0;
      err_o      = 1'b0;
      err_code_o = 2'b00;
    end
  end

  assign alu_op = ALU_OP_W'(alu_op_int);

endmodule
